// File: rtl/gemm_ex_ctl_p.sv
// GEMM execution controller: walks ic (inner), dc (row) and oc (output-channel group)
// loops, issuing MAC cycles with input/weight buffer addresses and kernel/sequence pulses.
module gemm_ex_ctl_p #(
  parameter int IW  = 3,
  parameter int DW  = 2,
  parameter int OW  = 1,
  parameter int IAW = 5,
  parameter int WAW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           s_init,
  input  logic [IW-1:0]  cfg_ic_last,
  input  logic [DW-1:0]  cfg_dc_last,
  input  logic [OW-1:0]  cfg_oc_last,
  input  logic           stall,
  input  logic           out_busy,
  input  logic           outrf,
  output logic           k_init,
  output logic           k_fin,
  output logic           s_fin,
  output logic           exec,
  output logic [IAW-1:0] ia,
  output logic [WAW-1:0] wa,
  output logic           busy
);

  typedef enum logic [2:0] {IDLE, KINIT, EXEC, DRAIN, FIN} state_e;

  state_e         state_q, state_d;
  logic [IW-1:0]  ic_q, ic_d, ic_last_q, ic_last_d;
  logic [DW-1:0]  dc_q, dc_d, dc_last_q, dc_last_d;
  logic [OW-1:0]  oc_q, oc_d, oc_last_q, oc_last_d;
  logic [IAW-1:0] dbase_q, dbase_d, ia_step;
  logic [WAW-1:0] obase_q, obase_d, wa_step;
  logic           kfin_q, kfin_d;

  // Each row / output group occupies ic_last+1 consecutive buffer entries.
  assign ia_step = IAW'(ic_last_q) + IAW'(1);
  assign wa_step = WAW'(ic_last_q) + WAW'(1);

  assign ia    = dbase_q + IAW'(ic_q);
  assign wa    = obase_q + WAW'(ic_q);
  assign busy  = (state_q != IDLE);
  assign k_fin = kfin_q;

  always_comb begin
    state_d   = state_q;
    ic_d      = ic_q;
    dc_d      = dc_q;
    oc_d      = oc_q;
    ic_last_d = ic_last_q;
    dc_last_d = dc_last_q;
    oc_last_d = oc_last_q;
    dbase_d   = dbase_q;
    obase_d   = obase_q;
    kfin_d    = 1'b0;
    k_init    = 1'b0;
    exec      = 1'b0;
    s_fin     = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_init) begin
          ic_last_d = cfg_ic_last;
          dc_last_d = cfg_dc_last;
          oc_last_d = cfg_oc_last;
          ic_d      = '0;
          dc_d      = '0;
          oc_d      = '0;
          dbase_d   = '0;
          obase_d   = '0;
          state_d   = KINIT;
        end
      end
      KINIT: begin
        k_init = !out_busy;
        if (!out_busy) begin
          ic_d    = '0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        exec = !stall;
        if (!stall) begin
          if (ic_q != ic_last_q) begin
            ic_d = ic_q + IW'(1);
          end else begin
            ic_d   = '0;
            kfin_d = 1'b1;
            // Kernel end: advance dc, carrying into oc on dc wrap.
            if (dc_q == dc_last_q) begin
              dc_d    = '0;
              dbase_d = '0;
              oc_d    = (oc_q == oc_last_q) ? '0 : oc_q + OW'(1);
              obase_d = obase_q + wa_step;
            end else begin
              dc_d    = dc_q + DW'(1);
              dbase_d = dbase_q + ia_step;
            end
            state_d = (dc_q == dc_last_q && oc_q == oc_last_q) ? DRAIN : KINIT;
          end
        end
      end
      DRAIN: if (outrf) state_d = FIN;
      FIN: begin
        s_fin   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      ic_q      <= '0;
      dc_q      <= '0;
      oc_q      <= '0;
      ic_last_q <= '0;
      dc_last_q <= '0;
      oc_last_q <= '0;
      dbase_q   <= '0;
      obase_q   <= '0;
      kfin_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ic_q      <= ic_d;
      dc_q      <= dc_d;
      oc_q      <= oc_d;
      ic_last_q <= ic_last_d;
      dc_last_q <= dc_last_d;
      oc_last_q <= oc_last_d;
      dbase_q   <= dbase_d;
      obase_q   <= obase_d;
      kfin_q    <= kfin_d;
    end
  end

endmodule

// File: doc/gemm_ex_ctl_p.md
GEMM_EX_CTL_P -- requirements
Module: gemm_ex_ctl_p

Interface
REQ-001 Parameter IW, default 3: width of the inner (ic) counter and of cfg_ic_last.
REQ-002 Parameter DW, default 2: width of the row (dc) counter and of cfg_dc_last.
REQ-003 Parameter OW, default 1: width of the output-channel-group (oc) counter and of cfg_oc_last.
REQ-004 Parameter IAW, default 5: width of ia. Parameter WAW, default 4: width of wa.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 s_init  in  1  start pulse; honoured only in IDLE.
REQ-008 cfg_ic_last / cfg_dc_last / cfg_oc_last  in  IW/DW/OW  last index of each loop; sampled only with an honoured s_init.
REQ-009 stall  in  1  input operand not ready; freezes an EXEC cycle.
REQ-010 out_busy  in  1  output stage cannot accept a new kernel.
REQ-011 outrf  in  1  output stage drained (result FIFO empty).
REQ-012 k_init / k_fin / s_fin  out  1  kernel-start, kernel-end and sequence-end pulses.
REQ-013 exec  out  1  a MAC cycle is issued this cycle, with ia/wa valid.
REQ-014 ia  out  IAW  input-buffer address. wa  out  WAW  weight-buffer address.
REQ-015 busy  out  1  high in every state except IDLE.

Function
REQ-016 States SHALL be IDLE, KINIT, EXEC, DRAIN, FIN; loop order, innermost first: ic, then dc, then oc.
REQ-017 IDLE: s_init=1 -> latch cfg_*, clear ic/dc/oc, clear both address bases, go to KINIT next cycle; otherwise remain in IDLE.
REQ-018 KINIT: k_init = !out_busy; on !out_busy go to EXEC with ic=0; on out_busy hold KINIT with k_init=0.
REQ-019 EXEC: exec = !stall; when stall=1, all counters and outputs except exec hold.
REQ-020 When exec=1 and ic<ic_last, ic increments by 1.
REQ-021 When exec=1 and ic=ic_last: ic wraps to 0, k_fin pulses on the next cycle, and the next state is KINIT if any outer loop remains, otherwise DRAIN.
REQ-022 At a kernel end, dc advances (wraps to 0 at dc_last, carrying into oc); a kernel end with dc=dc_last and oc=oc_last is the final kernel.
REQ-023 ia SHALL equal dbase+ic, where dbase += ic_last+1 on each dc advance and clears on dc wrap; ia is truncated modulo 2^IAW.
REQ-024 wa SHALL equal obase+ic, where obase += ic_last+1 on each oc advance; wa is truncated modulo 2^WAW.
REQ-025 ia and wa are combinational from the registered counters; their value is don't-care when exec=0.
REQ-026 DRAIN: when outrf=1 is sampled, go to FIN; FIN asserts s_fin for exactly one cycle, then returns to IDLE.
REQ-027 In the cycle after a non-final kernel end, k_fin and k_init SHALL be coincident when out_busy=0.
REQ-028 s_init outside IDLE is ignored, and cfg_* changes outside an honoured s_init have no effect.
REQ-029 With cfg_ic_last=0, every kernel is a single exec cycle; with all cfg_*=0, the sequence is exactly one kernel.
REQ-030 Latency: from s_init in cycle 0, k_init is in cycle 1 and the first exec is in cycle 2, assuming no out_busy and no stall.

Reset
REQ-031 While rst=0, state=IDLE, all counters, bases and latched cfg values=0, and k_init=k_fin=s_fin=exec=busy=0, ia=0, wa=0.
REQ-032 Reset asserted mid-sequence aborts the sequence immediately with no s_fin or k_fin pulse; after release the block accepts s_init normally.

Verification
REQ-033 Defaults with cfg=(7,3,0), no stall or busy: s_init at c0 -> k_init at c1, exec c2..c9 with ia 0..7, k_fin+k_init at c10, ia 8..15 next; 4 kernels; 32 exec cycles in total.
REQ-034 stall=1 for 3 cycles mid-kernel (ic=4): exec low for those cycles, ia holds 4, and the kernel ends 3 cycles later.
REQ-035 out_busy=1 held for 5 cycles after a kernel end: k_fin pulses once, k_init is delayed until out_busy=0, and no exec occurs meanwhile.
REQ-036 cfg=(1,1,1): wa is 0,1 for oc=0 and 2,3 for oc=1; ia is 0,1,2,3 repeated; DRAIN is entered; outrf=1 after 4 cycles -> s_fin one cycle later, then IDLE.
REQ-037 s_init pulsed during EXEC is ignored; rst low during EXEC gives all outputs 0 asynchronously, and no s_fin pulse follows.
REQ-038 All cfg=0: exactly one k_init, one exec with ia=0 and wa=0, then one k_fin, then s_fin after outrf.
